run_mode_controller: RTL and testbench

RUN_MODE_CONTROLLER -- requirements
Module: run_mode_controller

---
 rtl/run_mode_controller_if.sv | 31 +++
 rtl/run_mode_controller.sv | 162 ++++++++++++++++
 tb/tb_run_mode_controller.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/run_mode_controller_if.sv
// Pixel-in / code-word-out handshake bundle for run_mode_controller.
interface run_mode_controller_if #(
  parameter int unsigned pixel_length    = 8,
  parameter int unsigned runcount_length = 16,
  parameter int unsigned mode_length     = 2
);
  logic                       start_enc;
  logic                       pix_valid;
  logic                       pix_ready;
  logic [pixel_length-1:0]    a;
  logic [pixel_length-1:0]    x;
  logic [mode_length-1:0]     mode;
  logic                       code_valid;
  logic                       code_ready;
  logic [15:0]                code_bits;
  logic [4:0]                 code_len;
  logic [4:0]                 run_index;
  logic [runcount_length-1:0] run_count;

  // Driver side: feeds pixels, consumes code words.
  modport master (
    output start_enc, pix_valid, a, x, mode, code_ready,
    input  pix_ready, code_valid, code_bits, code_len, run_index, run_count
  );

  // Controller side.
  modport slave (
    input  start_enc, pix_valid, a, x, mode, code_ready,
    output pix_ready, code_valid, code_bits, code_len, run_index, run_count
  );
endinterface

// File: rtl/run_mode_controller.sv
// Run-mode controller: counts run pixels, adapts RUNindex and emits run codes.
module run_mode_controller #(
  parameter int unsigned pixel_length    = 8,
  parameter int unsigned runcount_length = 16,
  parameter int unsigned mode_length     = 2
) (
  input logic                  clk,
  input logic                  reset,
  run_mode_controller_if.slave bus
);

  localparam int unsigned code_width = 16;
  localparam int unsigned len_width  = 5;
  localparam int unsigned idx_width  = 5;
  localparam int unsigned j_width    = 4;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    EMIT_SEG,
    EMIT_INT,
    EMIT_EOL
  } state_t;

  state_t                     state;
  logic [runcount_length-1:0] run_count;
  logic [idx_width-1:0]       run_index;
  logic                       code_valid;
  logic [code_width-1:0]      code_bits;
  logic [len_width-1:0]       code_len;
  logic                       eol_pend;

  logic [pixel_length-1:0]    a_c;
  logic [pixel_length-1:0]    x_c;
  logic [mode_length-1:0]     mode_c;
  logic                       match_c;
  logic                       run_mode_c;
  logic                       eol_mode_c;
  logic [j_width-1:0]         j_c;
  logic [runcount_length-1:0] cnt_inc_c;
  logic [runcount_length-1:0] seg_len_c;
  logic                       seg_full_c;
  logic [code_width-1:0]      int_bits_c;

  // J table: 4 entries each of 0..3, pairs of 4..7, then singles 8..15.
  function automatic logic [j_width-1:0] j_lookup(input logic [idx_width-1:0] idx);
    if (idx < idx_width'(16))
      return j_width'(idx >> 2);
    else if (idx < idx_width'(24))
      return j_width'(idx_width'(4) + ((idx - idx_width'(16)) >> 1));
    else
      return j_width'(idx - idx_width'(16));
  endfunction

  // Pixel classification and segment arithmetic for the current RUNindex.
  assign a_c        = bus.a;
  assign x_c        = bus.x;
  assign mode_c     = bus.mode;
  assign match_c    = (x_c == a_c);
  assign run_mode_c = (mode_c == mode_length'(1));
  assign eol_mode_c = (mode_c == mode_length'(3));
  assign j_c        = j_lookup(run_index);
  assign cnt_inc_c  = run_count + runcount_length'(1);
  assign seg_len_c  = runcount_length'(1) << j_c;
  assign seg_full_c = (cnt_inc_c == seg_len_c);
  assign int_bits_c = code_width'(run_count) & ((code_width'(1) << j_c) - code_width'(1));

  // pix_ready must drop in the same cycle start_enc falls, so it is gated live.
  assign bus.pix_ready  = (state == ACCEPT) && bus.start_enc;
  assign bus.code_valid = code_valid;
  assign bus.code_bits  = code_bits;
  assign bus.code_len   = code_len;
  assign bus.run_index  = run_index;
  assign bus.run_count  = run_count;

  // Controller FSM with registered code-word outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      run_count  <= '0;
      run_index  <= '0;
      code_valid <= 1'b0;
      code_bits  <= '0;
      code_len   <= '0;
      eol_pend   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_enc) state <= ACCEPT;
        end

        ACCEPT: begin
          if (!bus.start_enc) begin
            state <= IDLE;
          end else if (bus.pix_valid && (mode_c != mode_length'(0))) begin
            if (match_c && (run_mode_c || eol_mode_c)) begin
              run_count <= cnt_inc_c;
              if (seg_full_c) begin
                state      <= EMIT_SEG;
                code_valid <= 1'b1;
                code_bits  <= code_width'(1);
                code_len   <= len_width'(1);
                eol_pend   <= eol_mode_c;
              end else if (eol_mode_c) begin
                state      <= EMIT_EOL;
                code_valid <= 1'b1;
                code_bits  <= code_width'(1);
                code_len   <= len_width'(1);
              end
            end else begin
              state      <= EMIT_INT;
              code_valid <= 1'b1;
              code_bits  <= int_bits_c;
              code_len   <= len_width'(j_c) + len_width'(1);
            end
          end
        end

        EMIT_SEG: begin
          if (bus.code_ready) begin
            run_count  <= '0;
            run_index  <= (run_index == idx_width'(31)) ? run_index : run_index + idx_width'(1);
            code_valid <= 1'b0;
            code_bits  <= '0;
            code_len   <= '0;
            eol_pend   <= 1'b0;
            state      <= eol_pend ? EMIT_EOL : ACCEPT;
          end
        end

        EMIT_INT: begin
          if (bus.code_ready) begin
            run_count  <= '0;
            run_index  <= (run_index == '0) ? run_index : run_index - idx_width'(1);
            code_valid <= 1'b0;
            code_bits  <= '0;
            code_len   <= '0;
            state      <= ACCEPT;
          end
        end

        EMIT_EOL: begin
          // A zero count here means the segment code already closed the run.
          if (run_count != '0) begin
            if (bus.code_ready) begin
              run_count  <= '0;
              code_valid <= 1'b0;
              code_bits  <= '0;
              code_len   <= '0;
              state      <= ACCEPT;
            end
          end else begin
            state <= ACCEPT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_mode_controller.sv
// Directed and randomized bench for run_mode_controller against an event-level run model.
module tb_run_mode_controller;

  localparam int unsigned PL = 8;
  localparam int unsigned RL = 16;
  localparam int unsigned ML = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  run_mode_controller_if #(.pixel_length(PL), .runcount_length(RL), .mode_length(ML)) bus ();

  run_mode_controller #(.pixel_length(PL), .runcount_length(RL), .mode_length(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int jt [32] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};

  // Reference state: RUNindex, RUNcnt, queued code words, and whether an empty EOL cycle follows.
  int m_idx = 0;
  int m_cnt = 0;
  int exp_bits [$];
  int exp_len  [$];
  bit m_gap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply the run-coding rules to one accepted pixel.
  task automatic mdl_pixel(input int m, input bit hit);
    int seg;
    m_gap = 0;
    seg = 1 << jt[m_idx];
    if (m == 0) begin
      // regular-mode pixel: run state untouched
    end else if (hit && (m == 1 || m == 3)) begin
      m_cnt++;
      if (m_cnt == seg) begin
        exp_bits.push_back(1); exp_len.push_back(1);
        m_cnt = 0;
        m_idx = (m_idx < 31) ? m_idx + 1 : 31;
        m_gap = (m == 3);
      end else if (m == 3) begin
        exp_bits.push_back(1); exp_len.push_back(1);
        m_cnt = 0;
      end
    end else begin
      exp_bits.push_back(m_cnt % seg); exp_len.push_back(jt[m_idx] + 1);
      m_cnt = 0;
      m_idx = (m_idx > 0) ? m_idx - 1 : 0;
    end
  endtask

  // Offer one pixel, then check and drain every code word it produces. Entered and left on a negedge.
  task automatic send(input int m, input bit hit, input int stall);
    bit got;
    int waited;
    int eb, el;
    logic [PL-1:0] av;
    av = PL'($urandom);
    bus.a = av;
    bus.x = hit ? av : (av ^ PL'($urandom_range(1, 255)));
    bus.mode = ML'(m);
    bus.pix_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 64; i++) begin
      check("no_code_while_idle", bus.code_valid, 0);
      if (bus.pix_ready === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check("pix_accepted", got, 1);
    if (!got) begin
      bus.pix_valid = 1'b0;
      return;
    end
    check("run_index", bus.run_index, m_idx);
    check("run_count", bus.run_count, m_cnt);
    @(posedge clk);
    mdl_pixel(m, hit);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    check("code_latency", bus.code_valid, exp_len.size() > 0);
    if (exp_len.size() > 0) begin
      while (exp_len.size() > 0) begin
        waited = 0;
        while (bus.code_valid !== 1'b1 && waited < 8) begin
          @(negedge clk);
          waited++;
        end
        eb = exp_bits.pop_front();
        el = exp_len.pop_front();
        check("code_valid", bus.code_valid, 1);
        check("code_bits", bus.code_bits, eb);
        check("code_len", bus.code_len, el);
        if (stall > 0) begin
          bus.code_ready = 1'b0;
          repeat (stall) begin
            @(negedge clk);
            check("stall_valid", bus.code_valid, 1);
            check("stall_bits", bus.code_bits, eb);
            check("stall_len", bus.code_len, el);
            check("stall_pix_ready", bus.pix_ready, 0);
          end
          bus.code_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
      end
      check("ready_after_xfer", bus.pix_ready, !m_gap);
    end
  endtask

  initial begin
    int r;
    int stall;
    reset = 1'b0;
    bus.start_enc = 1'b0;
    bus.pix_valid = 1'b0;
    bus.code_ready = 1'b1;
    bus.a = '0;
    bus.x = '0;
    bus.mode = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_pix_ready", bus.pix_ready, 0);
    check("rst_code_valid", bus.code_valid, 0);
    check("rst_code_bits", bus.code_bits, 0);
    check("rst_code_len", bus.code_len, 0);
    check("rst_run_index", bus.run_index, 0);
    check("rst_run_count", bus.run_count, 0);

    // Encoder disabled: a valid pixel is never accepted.
    reset = 1'b1;
    bus.pix_valid = 1'b1;
    bus.mode = 2'd1;
    bus.a = 8'h33;
    bus.x = 8'h33;
    repeat (3) begin
      @(negedge clk);
      check("disabled_pix_ready", bus.pix_ready, 0);
    end
    check("disabled_run_count", bus.run_count, 0);
    bus.pix_valid = 1'b0;
    bus.start_enc = 1'b1;
    @(negedge clk);

    // Index 0: one matching run pixel fills the segment.
    send(1, 1, 0);
    check("seg0_run_index", bus.run_index, 1);
    check("seg0_run_count", bus.run_count, 0);

    // Climb to index 8 (J=2), 3 hits then interruption -> 0b011 / len 3.
    while (m_idx < 8) send(1, 1, 0);
    repeat (3) send(1, 1, 0);
    check("int8_run_count", bus.run_count, 3);
    send(2, 0, 0);
    check("int8_run_index", bus.run_index, 7);

    // Down to index 4, one hit, then EOL hit fills the segment; EOL itself is silent.
    repeat (3) send(2, 0, 0);
    check("eol4_run_index_pre", bus.run_index, 4);
    send(1, 1, 0);
    send(3, 1, 0);
    @(negedge clk);
    check("eol4_code_valid", bus.code_valid, 0);
    check("eol4_pix_ready", bus.pix_ready, 1);
    check("eol4_run_index", bus.run_index, 5);
    check("eol4_run_count", bus.run_count, 0);

    // Randomized pixels, code stalls and encoder drops.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        bus.start_enc = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("drop_pix_ready", bus.pix_ready, 0);
        end
        bus.start_enc = 1'b1;
      end
      stall = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
      send($urandom_range(0, 3), $urandom_range(0, 9) < 7, stall);
    end

    // Interruption held off by code_ready=0 for 5 cycles.
    send(2, 0, 5);

    // Reset in the middle of a stalled code word discards it.
    bus.code_ready = 1'b0;
    bus.mode = 2'd2;
    bus.a = 8'h10;
    bus.x = 8'h20;
    bus.pix_valid = 1'b1;
    check("rststall_pix_ready", bus.pix_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    check("rststall_code_valid", bus.code_valid, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rststall_pix_ready0", bus.pix_ready, 0);
    check("rststall_valid0", bus.code_valid, 0);
    check("rststall_bits0", bus.code_bits, 0);
    check("rststall_len0", bus.code_len, 0);
    check("rststall_index0", bus.run_index, 0);
    check("rststall_count0", bus.run_count, 0);
    reset = 1'b1;
    bus.code_ready = 1'b1;
    m_idx = 0;
    m_cnt = 0;
    m_gap = 0;
    exp_bits.delete();
    exp_len.delete();
    @(negedge clk);

    // Top index: 32768 hits form a single segment and the index saturates.
    while (m_idx < 31) send(1, 1, 0);
    check("top_run_index", bus.run_index, 31);
    repeat (32768) send(1, 1, 0);
    check("top_run_index_after", bus.run_index, 31);
    check("top_run_count_after", bus.run_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
